// File: rtl/dcm_reset_sequencer.sv
// dcm_reset_sequencer
//
// Board clock/reset sequencer running on the buffered oscillator clock.
// Pulses the DCM RST pin, qualifies the DCM LOCKED signal, then releases two
// staged resets: peripherals/memory (resetStage0) first, the CPU
// (resetStage1) STAGE_GAP cycles later. Lock loss re-runs the whole DCM
// sequence; the reset button restarts only the lock-stability wait.
//
// Compile-time option:
//   DCM_LOCK_RETRY_EN  - a WAITLOCK timeout re-pulses the DCM and bumps the
//                        saturating retryCount output (port only exists
//                        when the macro is defined). Without it WAITLOCK
//                        waits for lock indefinitely.
//
// Ports:
//   clk          in   buffered oscillator clock (not a DCM output)
//   resetN       in   asynchronous active-low reset of this block
//   resetIn      in   reset button, active-high, asynchronous
//   dcmLocked    in   DCM LOCKED, asynchronous
//   dcmReset     out  DCM RST, active-high
//   resetStage0  out  peripheral/memory reset, active-high
//   resetStage1  out  CPU reset, active-high
//   ready        out  high only while fully running
//   retryCount   out  [3:0] saturating DCM retry count (DCM_LOCK_RETRY_EN)

module dcm_reset_sequencer #(
    parameter int unsigned CNT_WIDTH      = 24,
    parameter int unsigned DCM_RST_CYCLES = 3,
    parameter int unsigned LOCK_TIMEOUT   = 16777215,
    parameter int unsigned STABLE_CYCLES  = 1048576,
    parameter int unsigned STAGE_GAP      = 1024
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       resetIn,
    input  logic       dcmLocked,
    output logic       dcmReset,
    output logic       resetStage0,
    output logic       resetStage1,
`ifdef DCM_LOCK_RETRY_EN
    output logic       ready,
    output logic [3:0] retryCount
`else
    output logic       ready
`endif
);

    typedef enum logic [2:0] {
        DCMRST,
        WAITLOCK,
        STABLE,
        STAGE1,
        RUN
    } stateT;

    // Terminal counts: a state that must last N cycles leaves when cnt == N-1.
    localparam logic [CNT_WIDTH-1:0] DCM_RST_LAST = CNT_WIDTH'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST    = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(STAGE_GAP - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers: bit 0 = dcmLocked, bit 1 = resetIn
    // ------------------------------------------------------------------
    logic [1:0] asyncIn;
    logic [1:0] syncVec;
    logic       lockS;
    logic       buttonS;

    assign asyncIn = {resetIn, dcmLocked};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gSync
            logic metaReg;
            logic outReg;

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    metaReg <= 1'b0;
                    outReg  <= 1'b0;
                end else begin
                    metaReg <= asyncIn[gi];
                    outReg  <= metaReg;
                end
            end

            assign syncVec[gi] = outReg;
        end
    endgenerate

    assign lockS   = syncVec[0];
    assign buttonS = syncVec[1];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    stateT                stateReg, stateNext;
    logic [CNT_WIDTH-1:0] cntReg, cntNext;
    logic                 restartCnt;   // re-entry of STABLE from STABLE (button)
    logic                 holdCnt;      // freeze counter at its terminal value
    logic                 dcmResetReg, stage0Reg, stage1Reg, readyReg;
`ifdef DCM_LOCK_RETRY_EN
    logic                 retryHit;
    logic [3:0]           retryCountReg;
`endif

    always_comb begin
        stateNext  = stateReg;
        restartCnt = 1'b0;
        holdCnt    = 1'b0;
`ifdef DCM_LOCK_RETRY_EN
        retryHit   = 1'b0;
`endif
        unique case (stateReg)
            DCMRST: begin
                if (cntReg == DCM_RST_LAST) begin
                    stateNext = WAITLOCK;
                end
            end
            WAITLOCK: begin
                // Lock arriving on the timeout cycle still counts as lock.
                if (lockS) begin
                    stateNext = STABLE;
                end else if (cntReg == LOCK_LAST) begin
`ifdef DCM_LOCK_RETRY_EN
                    stateNext = DCMRST;
                    retryHit  = 1'b1;
`else
                    holdCnt   = 1'b1;
`endif
                end
            end
            STABLE: begin
                // Lock loss outranks the button; the button outranks the
                // stability count so a held button pins cnt at zero.
                if (!lockS) begin
                    stateNext = DCMRST;
                end else if (buttonS) begin
                    restartCnt = 1'b1;
                end else if (cntReg == STABLE_LAST) begin
                    stateNext = STAGE1;
                end
            end
            STAGE1: begin
                if (!lockS) begin
                    stateNext = DCMRST;
                end else if (buttonS) begin
                    stateNext = STABLE;
                end else if (cntReg == GAP_LAST) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (!lockS) begin
                    stateNext = DCMRST;
                end else if (buttonS) begin
                    stateNext = STABLE;
                end
            end
            default: begin
                stateNext = DCMRST;
            end
        endcase

        // Counter clears on every state entry and saturates otherwise.
        if ((stateNext != stateReg) || restartCnt) begin
            cntNext = '0;
        end else if (holdCnt || (&cntReg)) begin
            cntNext = cntReg;
        end else begin
            cntNext = cntReg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateReg <= DCMRST;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    // Outputs are decoded from stateNext so they move on the same edge as
    // the transition that causes them.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dcmResetReg <= 1'b1;
            stage0Reg   <= 1'b1;
            stage1Reg   <= 1'b1;
            readyReg    <= 1'b0;
        end else begin
            dcmResetReg <= (stateNext == DCMRST);
            stage0Reg   <= (stateNext == DCMRST) || (stateNext == WAITLOCK) ||
                           (stateNext == STABLE);
            stage1Reg   <= (stateNext != RUN);
            readyReg    <= (stateNext == RUN);
        end
    end

    assign dcmReset    = dcmResetReg;
    assign resetStage0 = stage0Reg;
    assign resetStage1 = stage1Reg;
    assign ready       = readyReg;

`ifdef DCM_LOCK_RETRY_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            retryCountReg <= 4'd0;
        end else if (retryHit && (retryCountReg != 4'd15)) begin
            retryCountReg <= retryCountReg + 4'd1;
        end
    end

    assign retryCount = retryCountReg;
`endif

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Testbench for dcm_reset_sequencer. Expected output waveforms are derived
// from edge arithmetic: "input sampled at edge x" plus synchronizer and state
// durations give the edge index at which each output changes.
// Build with DCM_LOCK_RETRY_EN defined to exercise the retry counter.

module tb_dcm_reset_sequencer;

    localparam int D  = 3;    // DCM reset pulse length
    localparam int TO = 20;   // lock timeout
    localparam int S  = 8;    // stable cycles
    localparam int G  = 4;    // stage gap

    logic clk       = 1'b0;
    logic resetN    = 1'b1;
    logic resetIn   = 1'b0;
    logic dcmLocked = 1'b0;
    logic dcmReset, resetStage0, resetStage1, ready;
`ifdef DCM_LOCK_RETRY_EN
    logic [3:0] retryCount;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;   // index of the last posedge since resetN release

    always #5 clk = ~clk;

    dcm_reset_sequencer #(
        .CNT_WIDTH      (8),
        .DCM_RST_CYCLES (D),
        .LOCK_TIMEOUT   (TO),
        .STABLE_CYCLES  (S),
        .STAGE_GAP      (G)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .resetIn     (resetIn),
        .dcmLocked   (dcmLocked),
        .dcmReset    (dcmReset),
        .resetStage0 (resetStage0),
        .resetStage1 (resetStage1),
`ifdef DCM_LOCK_RETRY_EN
        .ready       (ready),
        .retryCount  (retryCount)
`else
        .ready       (ready)
`endif
    );

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for two edges, release just after an edge; cyc 0 = reset state.
    task automatic do_reset(input logic lockLevel);
        resetN    = 1'b0;
        resetIn   = 1'b0;
        dcmLocked = lockLevel;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc    = 0;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reset values, both asynchronously and across clock edges while held.
    task automatic test_reset();
        logic [3:0] obs;
        #2;
        resetN = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            obs = {dcmReset, resetStage0, resetStage1, ready};
            vectors++;
            if (obs !== 4'b1110) begin
                miscompares++;
                $display("FAIL reset_values i=%0d got %b expected 1110", i, obs);
            end
`ifdef DCM_LOCK_RETRY_EN
            vectors++;
            if (retryCount !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_retry i=%0d got %0d expected 0", i, retryCount);
            end
`endif
            dcmLocked = 1'b1;
            resetIn   = 1'b1;
            @(posedge clk);
            #1;
        end
        resetIn = 1'b0;
        $display("test_reset: done");
    endtask

    // Cold start: dcmLocked sampled high from edge D+lat onward. Optional
    // button presses while the DCM is still resetting/locking must be ignored.
    task automatic run_cold(input int lat, input bit early, input int stopN);
        int a, f0;
        logic [3:0] expv, obs;
        a  = D + lat;
        f0 = a + 2 + S;
        do_reset(1'b0);
        while (1) begin
            expv = {cyc < D, cyc < f0, cyc < f0 + G, cyc >= f0 + G};
            obs  = {dcmReset, resetStage0, resetStage1, ready};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL cold_start cyc=%0d lat=%0d got %b expected %b", cyc, lat, obs, expv);
            end
            vectors++;
            if ((!resetStage1 && resetStage0) || (dcmReset && !(resetStage0 && resetStage1))) begin
                miscompares++;
                $display("FAIL invariant cyc=%0d got %b expected consistent outputs", cyc, obs);
            end
            if (cyc >= stopN) break;
            dcmLocked = (cyc + 1 >= a);
            resetIn   = early && (cyc + 1 < a);
            tick();
        end
`ifdef DCM_LOCK_RETRY_EN
        vectors++;
        if (retryCount !== 4'd0) begin
            miscompares++;
            $display("FAIL cold_retry got %0d expected 0", retryCount);
        end
`endif
    endtask

    task automatic test_cold_start();
        run_cold(5, 1'b0, D + 5 + 2 + S + G + 4);
        for (int k = 0; k < 4; k++) begin
            int lat;
            lat = $urandom_range(0, 15);
            run_cold(lat, 1'(k & 1), D + lat + 2 + S + G + 3);
        end
        $display("test_cold_start: done, lat 5 plus 4 random");
    endtask

    // One-cycle lock dropout while counting stability.
    task automatic test_stable_glitch();
        for (int k = 0; k < 3; k++) begin
            int lat, a, g, e, f0;
            logic [3:0] expv, obs;
            lat = $urandom_range(0, 10);
            a   = D + lat;
            run_cold(lat, 1'b0, a);
            g  = a + 1 + $urandom_range(0, S - 1);
            e  = g + 2;
            f0 = e + D + 1 + S;
            while (cyc < f0 + G + 3) begin
                dcmLocked = (cyc + 1 != g);
                tick();
                expv = {cyc >= e && cyc < e + D, cyc < f0, cyc < f0 + G, cyc >= f0 + G};
                obs  = {dcmReset, resetStage0, resetStage1, ready};
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL stable_glitch cyc=%0d g=%0d got %b expected %b", cyc, g, obs, expv);
                end
            end
            $display("test_stable_glitch: glitch at edge %0d", g);
        end
    endtask

    // Lock drop while running, optionally together with a button press.
    task automatic test_run_lock_drop(input bit withButton);
        for (int k = 0; k < 3; k++) begin
            int lat, t, h, e, f0;
            logic [3:0] expv, obs;
            lat = $urandom_range(0, 10);
            run_cold(lat, 1'b0, D + lat + 2 + S + G + 2 + $urandom_range(0, 4));
            t  = cyc + 1 + $urandom_range(0, 3);
            h  = $urandom_range(1, 10);
            e  = t + 2;
            f0 = imax(t + h + 2, e + D + 1) + S;
            while (cyc < f0 + G + 3) begin
                dcmLocked = !((cyc + 1 >= t) && (cyc + 1 < t + h));
                resetIn   = withButton && (cyc + 1 >= t) && (cyc + 1 < t + 2);
                tick();
                expv = {cyc >= e && cyc < e + D, cyc >= e && cyc < f0,
                        cyc >= e && cyc < f0 + G, !(cyc >= e && cyc < f0 + G)};
                obs  = {dcmReset, resetStage0, resetStage1, ready};
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL lock_drop btn=%0d cyc=%0d t=%0d h=%0d got %b expected %b",
                             withButton, cyc, t, h, obs, expv);
                end
            end
            $display("test_run_lock_drop: button=%0d drop at edge %0d for %0d", withButton, t, h);
        end
    endtask

    // Button held H edges after lock is qualified (STABLE, STAGE1 or RUN).
    task automatic test_button();
        for (int k = 0; k < 4; k++) begin
            int lat, hold, b, c0, f0;
            logic [3:0] expv, obs;
            lat  = $urandom_range(0, 10);
            hold = (k == 0) ? 10 : $urandom_range(1, 12);
            c0   = D + lat + 2 + S;
            run_cold(lat, 1'b0, (k == 0) ? c0 + G + 2 : D + lat + 2 + $urandom_range(0, S + G + 3));
            b  = cyc + 1;
            f0 = b + hold + 1 + S;
            while (cyc < f0 + G + 3) begin
                resetIn = (cyc + 1 >= b) && (cyc + 1 < b + hold);
                tick();
                if (cyc < b + 2) expv = {1'b0, cyc < c0, cyc < c0 + G, cyc >= c0 + G};
                else             expv = {1'b0, cyc < f0, cyc < f0 + G, cyc >= f0 + G};
                obs = {dcmReset, resetStage0, resetStage1, ready};
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL button cyc=%0d b=%0d hold=%0d got %b expected %b", cyc, b, hold, obs, expv);
                end
            end
            $display("test_button: press at edge %0d held %0d", b, hold);
        end
    endtask

    // No lock ever: retry pulses every D+TO cycles with the macro, one pulse without.
    task automatic test_retry();
        logic [3:0] expv, obs;
        do_reset(1'b0);
        while (1) begin
`ifdef DCM_LOCK_RETRY_EN
            expv = {(cyc % (D + TO)) < D, 1'b1, 1'b1, 1'b0};
            vectors++;
            if (retryCount !== 4'(imax(0, (cyc / (D + TO) > 15) ? 15 : cyc / (D + TO)))) begin
                miscompares++;
                $display("FAIL retry_count cyc=%0d got %0d expected %0d", cyc, retryCount,
                         (cyc / (D + TO) > 15) ? 15 : cyc / (D + TO));
            end
`else
            expv = {cyc < D, 1'b1, 1'b1, 1'b0};
`endif
            obs = {dcmReset, resetStage0, resetStage1, ready};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL retry cyc=%0d got %b expected %b", cyc, obs, expv);
            end
            if (cyc >= (D + TO) * 17 + 3) break;
            resetIn = 1'($urandom_range(0, 1));
            tick();
        end
        resetIn = 1'b0;
        #3;
        resetN = 1'b0;
        #1;
`ifdef DCM_LOCK_RETRY_EN
        vectors++;
        if (retryCount !== 4'd0) begin
            miscompares++;
            $display("FAIL retry_async_clear got %0d expected 0", retryCount);
        end
`endif
        $display("test_retry: done after %0d cycles", cyc);
    endtask

    // resetN asserted between edges while in STAGE1.
    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            int lat;
            logic [3:0] obs;
            lat = $urandom_range(0, 10);
            run_cold(lat, 1'b0, D + lat + 2 + S + $urandom_range(0, G - 1));
            #3;
            resetN = 1'b0;
            #1;
            obs = {dcmReset, resetStage0, resetStage1, ready};
            vectors++;
            if (obs !== 4'b1110) begin
                miscompares++;
                $display("FAIL async_reset cyc=%0d got %b expected 1110", cyc, obs);
            end
            $display("test_async_reset: asserted at cycle %0d", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_stable_glitch();
        test_run_lock_drop(1'b0);
        test_button();
        test_run_lock_drop(1'b1);
        test_retry();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
